// File: rtl/pwm_if.sv
// pwm_if: control inputs and PWM outputs of the multi-channel PWM block.
interface pwm_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 8
);
    logic                    en;
    logic                    load;
    logic [CNT_W-1:0]        period;
    logic [NUM_CH*CNT_W-1:0] duty;
    logic                    center_mode;
    logic [NUM_CH-1:0]       pwm_out;
    logic                    period_end;
    logic                    load_ack;

    modport master (
        output en, load, period, duty, center_mode,
        input  pwm_out, period_end, load_ack
    );

    modport slave (
        input  en, load, period, duty, center_mode,
        output pwm_out, period_end, load_ack
    );
endinterface

// File: rtl/pwm_multi_channel.sv
// pwm_multi_channel: shared period counter, NUM_CH duty comparators, edge/centre modes,
// with shadow registers that take effect only at a period boundary.
module pwm_multi_channel #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 8
) (
    input logic  clk,
    input logic  rst,
    pwm_if.slave bus
);
    localparam logic [CNT_W-1:0] one = CNT_W'(1);

    logic [CNT_W-1:0]        cnt, p_act, p_sh;
    logic [NUM_CH*CNT_W-1:0] d_act, d_sh;
    logic                    dir, cm_act, cm_sh, pending;
    logic                    centre, wrap, apply_in, apply_sh;
    logic [NUM_CH-1:0]       cmp;

    // Centre mode with P<=1 degenerates to a plain wrap at cnt==P.
    always_comb begin
        centre   = cm_act && (p_act > one);
        wrap     = bus.en && (centre ? (dir && cnt == one) : (cnt == p_act));
        apply_in = bus.load && (!bus.en || wrap);
        apply_sh = wrap && pending && !bus.load;
    end

    genvar i;
    for (i = 0; i < NUM_CH; i++) begin : g_cmp
        assign cmp[i] = cnt < d_act[i*CNT_W +: CNT_W];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt            <= '0;
            dir            <= 1'b0;
            p_act          <= '0;
            d_act          <= '0;
            cm_act         <= 1'b0;
            p_sh           <= '0;
            d_sh           <= '0;
            cm_sh          <= 1'b0;
            pending        <= 1'b0;
            bus.pwm_out    <= '0;
            bus.period_end <= 1'b0;
            bus.load_ack   <= 1'b0;
        end else begin
            bus.pwm_out    <= bus.en ? cmp : '0;
            bus.period_end <= wrap;
            bus.load_ack   <= apply_in || apply_sh;
            if (!bus.en || wrap) begin
                cnt <= '0;
                dir <= 1'b0;
            end else if (dir) begin
                cnt <= cnt - one;
            end else if (centre && cnt == p_act) begin
                dir <= 1'b1;
                cnt <= cnt - one;
            end else begin
                cnt <= cnt + one;
            end
            if (apply_in) begin
                p_act   <= bus.period;
                d_act   <= bus.duty;
                cm_act  <= bus.center_mode;
                pending <= 1'b0;
            end else if (apply_sh) begin
                p_act   <= p_sh;
                d_act   <= d_sh;
                cm_act  <= cm_sh;
                pending <= 1'b0;
            end else if (bus.load) begin
                p_sh    <= bus.period;
                d_sh    <= bus.duty;
                cm_sh   <= bus.center_mode;
                pending <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_pwm_multi_channel.sv
// tb_pwm_multi_channel: table-driven period/duty checks, corner sequences, and
// randomized traffic against a position-in-period reference model.
module tb_pwm_multi_channel;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    pwm_if #(.NUM_CH(4), .CNT_W(8)) bus ();
    pwm_multi_channel #(.NUM_CH(4), .CNT_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // Reference model: position within the period, active/shadow settings as integers.
    int         m_pos, m_p, m_cm, m_pend, s_p, s_cm;
    int         m_d[4], s_d[4];
    logic [3:0] e_pwm;
    logic       e_pe, e_ack;

    function automatic void model_reset();
        m_pos = 0; m_p = 0; m_cm = 0; m_pend = 0; s_p = 0; s_cm = 0;
        for (int k = 0; k < 4; k++) begin
            m_d[k] = 0;
            s_d[k] = 0;
        end
        e_pwm = '0; e_pe = 1'b0; e_ack = 1'b0;
    endfunction

    function automatic void take_inputs(output int p, output int cm, output int d[4]);
        p  = int'(bus.period);
        cm = int'(bus.center_mode);
        for (int k = 0; k < 4; k++) d[k] = int'(bus.duty[k*8 +: 8]);
    endfunction

    function automatic void model_step();
        int len, c;
        len = (m_cm != 0 && m_p >= 1) ? 2 * m_p : m_p + 1;
        c   = (m_cm != 0 && m_p >= 1 && m_pos > m_p) ? 2 * m_p - m_pos : m_pos;
        for (int k = 0; k < 4; k++) e_pwm[k] = bus.en && (c < m_d[k]);
        e_pe  = bus.en && (m_pos == len - 1);
        e_ack = 1'b0;
        if (!bus.en || m_pos == len - 1) begin
            m_pos = 0;
            if (bus.load) begin
                take_inputs(m_p, m_cm, m_d);
                m_pend = 0;
                e_ack  = 1'b1;
            end else if (bus.en && m_pend != 0) begin
                m_p = s_p; m_cm = s_cm; m_d = s_d;
                m_pend = 0;
                e_ack  = 1'b1;
            end
        end else begin
            m_pos++;
            if (bus.load) begin
                take_inputs(s_p, s_cm, s_d);
                m_pend = 1;
            end
        end
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check("pwm_out", bus.pwm_out, e_pwm);
        check("period_end", bus.period_end, e_pe);
        check("load_ack", bus.load_ack, e_ack);
    endtask

    task automatic set_cfg(input int p, input int cm, input logic [31:0] d);
        bus.period      = 8'(p);
        bus.center_mode = cm[0];
        bus.duty        = d;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        bus.en = 1'b0;
        bus.load = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        rst = 1'b1;
    endtask

    task automatic wait_pe();
        int k;
        for (k = 0; k < 600 && !bus.period_end; k++) cycle();
        if (!bus.period_end) check("period_end_timeout", 0, 1);
    endtask

    task automatic measure(output int n, output int h[4]);
        n = 0;
        for (int k = 0; k < 4; k++) h[k] = 0;
        do begin
            for (int k = 0; k < 4; k++) h[k] += int'(bus.pwm_out[k]);
            n++;
            cycle();
        end while (!bus.period_end && n < 600);
    endtask

    typedef struct packed {
        logic [7:0]        p;
        logic              cm;
        logic [3:0][7:0]   d;
        logic [15:0]       len;
        logic [3:0][15:0]  hi;
    } vec_t;

    vec_t tbl[6];

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int h[4];
        bus.en = 1'b0; bus.load = 1'b0; bus.period = '0; bus.duty = '0; bus.center_mode = 1'b0;
        tbl[0] = '{p: 8'd9,   cm: 1'b0, d: {8'd12, 8'd10, 8'd3, 8'd0},  len: 16'd10,  hi: {16'd10, 16'd10, 16'd3, 16'd0}};
        tbl[1] = '{p: 8'd5,   cm: 1'b1, d: {8'd6, 8'd5, 8'd0, 8'd2},    len: 16'd10,  hi: {16'd10, 16'd9, 16'd0, 16'd3}};
        tbl[2] = '{p: 8'd255, cm: 1'b0, d: {8'd128, 8'd1, 8'd0, 8'd255}, len: 16'd256, hi: {16'd128, 16'd1, 16'd0, 16'd255}};
        tbl[3] = '{p: 8'd0,   cm: 1'b1, d: {8'd0, 8'd2, 8'd1, 8'd0},    len: 16'd1,   hi: {16'd0, 16'd1, 16'd1, 16'd0}};
        tbl[4] = '{p: 8'd1,   cm: 1'b1, d: {8'd1, 8'd0, 8'd2, 8'd1},    len: 16'd2,   hi: {16'd1, 16'd0, 16'd2, 16'd1}};
        tbl[5] = '{p: 8'd4,   cm: 1'b0, d: {8'd1, 8'd4, 8'd2, 8'd5},    len: 16'd5,   hi: {16'd1, 16'd4, 16'd2, 16'd5}};

        #3;
        check("reset_pwm_out", bus.pwm_out, 0);
        check("reset_period_end", bus.period_end, 0);
        check("reset_load_ack", bus.load_ack, 0);

        foreach (tbl[t]) begin
            do_reset();
            set_cfg(int'(tbl[t].p), int'(tbl[t].cm), tbl[t].d);
            bus.load = 1'b1;
            cycle();
            bus.load = 1'b0;
            check("ack_after_idle_load", bus.load_ack, 1);
            bus.en = 1'b1;
            wait_pe();
            measure(n, h);
            check($sformatf("tbl%0d_len", t), n, tbl[t].len);
            for (int k = 0; k < 4; k++) check($sformatf("tbl%0d_ch%0d_high", t, k), h[k], tbl[t].hi[k]);
        end

        // Mid-period duty update must wait for the wrap.
        do_reset();
        set_cfg(9, 0, {8'd12, 8'd10, 8'd3, 8'd0});
        bus.load = 1'b1;
        cycle();
        bus.load = 1'b0;
        bus.en = 1'b1;
        wait_pe();
        cycle();
        cycle();
        set_cfg(9, 0, {8'd12, 8'd10, 8'd7, 8'd0});
        bus.load = 1'b1;
        cycle();
        bus.load = 1'b0;
        wait_pe();
        check("midload_ack_with_pe", bus.load_ack, 1);
        measure(n, h);
        check("midload_len", n, 10);
        check("midload_ch1_high", h[1], 7);

        // Two loads in a period: last wins; a load in the wrap cycle applies at once.
        set_cfg(20, 0, {8'd12, 8'd10, 8'd3, 8'd0});
        bus.load = 1'b1;
        cycle();
        bus.load = 1'b0;
        cycle();
        set_cfg(4, 0, {8'd12, 8'd10, 8'd3, 8'd0});
        bus.load = 1'b1;
        cycle();
        bus.load = 1'b0;
        wait_pe();
        check("lastwin_ack", bus.load_ack, 1);
        measure(n, h);
        check("lastwin_len", n, 5);
        for (int k = 0; k < 4; k++) cycle();
        set_cfg(2, 0, {8'd12, 8'd10, 8'd3, 8'd0});
        bus.load = 1'b1;
        cycle();
        bus.load = 1'b0;
        check("wrapload_pe", bus.period_end, 1);
        check("wrapload_ack", bus.load_ack, 1);
        measure(n, h);
        check("wrapload_len", n, 3);

        // Asynchronous reset mid-period with outputs high.
        set_cfg(9, 0, {8'd12, 8'd12, 8'd12, 8'd12});
        bus.en = 1'b0;
        bus.load = 1'b1;
        cycle();
        bus.load = 1'b0;
        bus.en = 1'b1;
        wait_pe();
        for (int k = 0; k < 5; k++) cycle();
        check("prereset_high", bus.pwm_out, 4'hF);
        #2;
        rst = 1'b0;
        #1;
        check("async_pwm_out", bus.pwm_out, 0);
        check("async_period_end", bus.period_end, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        n = 0;
        for (int k = 0; k < 20; k++) begin
            cycle();
            n += int'(bus.pwm_out != 0);
        end
        check("post_reset_low", n, 0);

        // Randomized traffic against the reference model.
        for (int k = 0; k < 3000; k++) begin
            bus.en = ($urandom_range(0, 9) != 0);
            bus.load = ($urandom_range(0, 14) == 0);
            set_cfg($urandom_range(0, 12), $urandom_range(0, 1),
                    {8'($urandom_range(0, 14)), 8'($urandom_range(0, 14)),
                     8'($urandom_range(0, 14)), 8'($urandom_range(0, 14))});
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
